// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: two requesters (CPU, DMA) plus a single memory port.
// The slave modport is the arbiter's view and the master modport is the environment's view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 12
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_ack;
  logic [DATA_W-1:0] dma_rdata;

  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] ReadData;
  logic              busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_ack, dma_rdata,
    output MemRead, MemWrite, Address, WriteData, busy,
    input  ReadData
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_ack, dma_rdata,
    input  MemRead, MemWrite, Address, WriteData, busy,
    output ReadData
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (CPU/DMA) memory arbiter with a 4-cycle IDLE/SETUP/STROBE/DONE access.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise the CPU has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 12
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_e;

  state_e            state_q;
  logic              sel_dma_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              mem_rd_q;
  logic              mem_wr_q;
  logic              cpu_ack_q;
  logic              dma_ack_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dma_rdata_q;
  logic              busy_q;
  logic              grant_dma_d;
  logic              any_req;

  assign any_req = bus.cpu_req | bus.dma_req;

`ifdef MEM_ARB_RR_EN
  // rr_dma_q = 1 means the DMA is favoured on the next tie (CPU was granted last).
  logic rr_dma_q;

  always_comb begin
    grant_dma_d = bus.dma_req & (~bus.cpu_req | rr_dma_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_dma_q <= 1'b0;
    end else if (state_q == IDLE && any_req) begin
      rr_dma_q <= ~grant_dma_d;
    end
  end
`else
  always_comb begin
    grant_dma_d = bus.dma_req & ~bus.cpu_req;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_dma_q   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            sel_dma_q <= grant_dma_d;
            we_q      <= grant_dma_d ? bus.dma_we    : bus.cpu_we;
            addr_q    <= grant_dma_d ? bus.dma_addr  : bus.cpu_addr;
            wdata_q   <= grant_dma_d ? bus.dma_wdata : bus.cpu_wdata;
            busy_q    <= 1'b1;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          mem_rd_q <= ~we_q;
          mem_wr_q <= we_q;
          state_q  <= STROBE;
        end
        STROBE: begin
          mem_rd_q <= 1'b0;
          mem_wr_q <= 1'b0;
          if (!we_q) begin
            if (sel_dma_q) dma_rdata_q <= bus.ReadData;
            else           cpu_rdata_q <= bus.ReadData;
          end
          if (sel_dma_q) dma_ack_q <= 1'b1;
          else           cpu_ack_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          cpu_ack_q <= 1'b0;
          dma_ack_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.MemRead   = mem_rd_q;
  assign bus.MemWrite  = mem_wr_q;
  assign bus.Address   = addr_q;
  assign bus.WriteData = wdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.dma_ack   = dma_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed accesses push expected strobes/acks,
// a negedge monitor pops and compares them against what the arbiter presents.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(12), .DATA_W(12)) bus ();

  mem_arbiter #(.ADDR_W(12), .DATA_W(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory model: combinational read, write on the strobe edge, plus a preload port.
  logic [11:0] mem [0:4095];
  logic        ld_en = 1'b0;
  logic [11:0] ld_addr = '0;
  logic [11:0] ld_data = '0;

  assign bus.ReadData = mem[bus.Address];

  always @(posedge clk) begin
    if (ld_en)             mem[ld_addr] <= ld_data;
    else if (bus.MemWrite) mem[bus.Address] <= bus.WriteData;
  end

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [11:0] wdata;
  } strobe_t;

  typedef struct {
    logic        dma;
    logic        we;
    logic [11:0] rdata;
  } ack_t;

  strobe_t sq[$];
  ack_t    aq[$];

  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] exp_cpu_rdata = '0;
  logic [11:0] exp_dma_rdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor
  initial begin
    strobe_t s;
    ack_t    a;
    logic [11:0] win_rd, lose_rd, exp_lose;
    forever begin
      @(negedge clk);
      if (bus.MemRead || bus.MemWrite) begin
        check("strobe_exclusive", 32'(bus.MemRead & bus.MemWrite), 0);
        if (sq.size() == 0) begin
          fail("unexpected_strobe");
        end else begin
          s = sq.pop_front();
          check("strobe_we", 32'(bus.MemWrite), 32'(s.we));
          check("strobe_addr", 32'(bus.Address), 32'(s.addr));
          if (s.we) check("strobe_wdata", 32'(bus.WriteData), 32'(s.wdata));
          check("strobe_busy", 32'(bus.busy), 1);
        end
      end
      if (bus.cpu_ack || bus.dma_ack) begin
        check("ack_exclusive", 32'(bus.cpu_ack & bus.dma_ack), 0);
        check("ack_strobes_low", 32'(bus.MemRead | bus.MemWrite), 0);
        check("ack_busy", 32'(bus.busy), 1);
        if (aq.size() == 0) begin
          fail("unexpected_ack");
        end else begin
          a = aq.pop_front();
          check("ack_who", 32'(bus.dma_ack), 32'(a.dma));
          win_rd   = a.dma ? bus.dma_rdata : bus.cpu_rdata;
          lose_rd  = a.dma ? bus.cpu_rdata : bus.dma_rdata;
          exp_lose = a.dma ? exp_cpu_rdata : exp_dma_rdata;
          if (!a.we) begin
            check("read_rdata", 32'(win_rd), 32'(a.rdata));
            if (a.dma) exp_dma_rdata = a.rdata;
            else       exp_cpu_rdata = a.rdata;
          end else begin
            check("write_rdata_hold", 32'(win_rd), 32'(a.dma ? exp_dma_rdata : exp_cpu_rdata));
          end
          check("loser_rdata_hold", 32'(lose_rd), 32'(exp_lose));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [11:0] a, input logic [11:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;
    tick();
    tick();
    exp_cpu_rdata = '0;
    exp_dma_rdata = '0;
    rst = 1'b0;
  endtask

  task automatic wait_ack(input logic dma, output int cycles);
    cycles = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      cycles++;
      if (dma ? bus.dma_ack : bus.cpu_ack) return;
    end
    fail("ack_timeout");
  endtask

  // Starts from IDLE (#1 after an edge), leaves the arbiter back in IDLE.
  task automatic access(input logic dma, input logic we, input logic [11:0] addr,
                        input logic [11:0] wdata, input logic [11:0] rdata);
    int cyc;
    sq.push_back('{we: we, addr: addr, wdata: wdata});
    aq.push_back('{dma: dma, we: we, rdata: rdata});
    if (dma) begin
      bus.dma_we = we; bus.dma_addr = addr; bus.dma_wdata = wdata; bus.dma_req = 1'b1;
    end else begin
      bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata; bus.cpu_req = 1'b1;
    end
    wait_ack(dma, cyc);
    check("ack_latency", 32'(cyc), 3);
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;
    tick();
  endtask

  initial begin
    logic [3:0] order;
    int acks;
    int cyc;

    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] order;
    int acks;
    int cyc;

    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
    rst = 1'b1;

    preload(12'd40, 12'd1000);
    preload(12'd100, 12'd77);
    preload(12'd200, 12'd88);
    tick();

    check("rst_cpu_ack",   32'(bus.cpu_ack), 0);
    check("rst_dma_ack",   32'(bus.dma_ack), 0);
    check("rst_MemRead",   32'(bus.MemRead), 0);
    check("rst_MemWrite",  32'(bus.MemWrite), 0);
    check("rst_busy",      32'(bus.busy), 0);
    check("rst_Address",   32'(bus.Address), 0);
    check("rst_WriteData", 32'(bus.WriteData), 0);
    check("rst_cpu_rdata", 32'(bus.cpu_rdata), 0);
    check("rst_dma_rdata", 32'(bus.dma_rdata), 0);
    rst = 1'b0;

    // Basic reads/writes from both requesters
    access(1'b0, 1'b0, 12'd40,   12'd0,  12'd1000);
    access(1'b1, 1'b1, 12'd2000, 12'd11, 12'd0);
    access(1'b1, 1'b0, 12'd2000, 12'd0,  12'd11);
    access(1'b0, 1'b1, 12'd300,  12'd5,  12'd0);
    access(1'b0, 1'b0, 12'd300,  12'd0,  12'd5);

    // Simultaneous requests held for four accesses; bit i = DMA wins access i
    apply_reset();
`ifdef MEM_ARB_RR_EN
    order = 4'b1010;
`else
    order = 4'b0000;
`endif
    for (int i = 0; i < 4; i++) begin
      if (order[i]) begin
        sq.push_back('{we: 1'b0, addr: 12'd200, wdata: 12'd0});
        aq.push_back('{dma: 1'b1, we: 1'b0, rdata: 12'd88});
      end else begin
        sq.push_back('{we: 1'b0, addr: 12'd100, wdata: 12'd0});
        aq.push_back('{dma: 1'b0, we: 1'b0, rdata: 12'd77});
      end
    end
    bus.cpu_we = 1'b0; bus.cpu_addr = 12'd100; bus.cpu_req = 1'b1;
    bus.dma_we = 1'b0; bus.dma_addr = 12'd200; bus.dma_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 40 && acks < 4; i++) begin
      tick();
      if (bus.cpu_ack || bus.dma_ack) acks++;
    end
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;
    check("simul_ack_count", 32'(acks), 4);
    repeat (6) tick();

    // Reset during STROBE of a write to 43: no ack, everything idle next cycle
    apply_reset();
    sq.push_back('{we: 1'b1, addr: 12'd43, wdata: 12'd5});
    bus.cpu_we = 1'b1; bus.cpu_addr = 12'd43; bus.cpu_wdata = 12'd5; bus.cpu_req = 1'b1;
    tick();
    check("setup_busy", 32'(bus.busy), 1);
    check("setup_strobes_low", 32'(bus.MemRead | bus.MemWrite), 0);
    check("setup_Address", 32'(bus.Address), 43);
    tick();
    check("strobe_MemWrite", 32'(bus.MemWrite), 1);
    rst = 1'b1;
    bus.cpu_req = 1'b0;
    tick();
    check("abort_MemWrite", 32'(bus.MemWrite), 0);
    check("abort_MemRead",  32'(bus.MemRead), 0);
    check("abort_busy",     32'(bus.busy), 0);
    check("abort_cpu_ack",  32'(bus.cpu_ack), 0);
    rst = 1'b0;
    exp_cpu_rdata = '0;
    exp_dma_rdata = '0;
    repeat (5) tick();
    access(1'b0, 1'b0, 12'd40, 12'd0, 12'd1000);

    // cpu_req dropped during SETUP: access completes once, no regrant
    sq.push_back('{we: 1'b0, addr: 12'd100, wdata: 12'd0});
    aq.push_back('{dma: 1'b0, we: 1'b0, rdata: 12'd77});
    bus.cpu_we = 1'b0; bus.cpu_addr = 12'd100; bus.cpu_req = 1'b1;
    tick();
    bus.cpu_req = 1'b0;
    wait_ack(1'b0, cyc);
    check("early_drop_latency", 32'(cyc), 2);
    repeat (8) tick();

    check("strobe_queue_drained", 32'(sq.size()), 0);
    check("ack_queue_drained", 32'(aq.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
